uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that sits directly downstream of the baud-rate tick generator. It buffers bytes from the host logic in a small FIFO and shifts each one out on `txd` as an asynchronous UART frame. The frame is LSB first, with optional parity and 1 or 2 stop bits. Every bit boundary is paced only by the one-cycle `baud_tick` strobe that the tick generator produces once per bit period.

## Interface
- `DATA_BITS`, 8: payload bits per frame, 5..8.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `baud_tick`  in  1  one-`clk`-cycle strobe, one per bit period.
- `tx_data`  in  DATA_BITS  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept; equals !full.
- `txd`  out  1  serial line, idle high.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Push:** occurs when `tx_valid & tx_ready` at a `clk` edge. `tx_data` is written at the tail and `fifo_count` increments.
- **Full FIFO:** `tx_ready`=0 and pushes are ignored. This holds even if a pop happens in the same cycle.
- **Pop:** only the FSM pops, at frame start. A push and a pop in the same cycle leave `fifo_count` unchanged.
- **State changes:** the FSM states are IDLE, START, DATA, PAR, STOP. All state changes and `txd` updates happen only on edges where `baud_tick`=1. No other edge changes `txd`.
- **IDLE:**
  - `txd`=1.
  - On a tick with `fifo_count`≠0: pop the head into the shift register, drive `txd`=0, go to START.
- **START:**
  - On a tick, drive data bit 0, set `bit_idx`=0, go to DATA.
- **DATA:**
  - On a tick with `bit_idx` < DATA_BITS-1: shift, drive the next bit, and increment `bit_idx`.
  - On a tick with `bit_idx` = DATA_BITS-1:
    - If PARITY≠0, drive the parity bit and go to PAR.
    - Otherwise drive `txd`=1 and go to STOP.
- **PAR:**
  - The parity bit is computed over the popped byte.
  - Even parity is the XOR of the data bits; odd parity is its inverse.
  - On a tick, drive `txd`=1 and go to STOP with `stop_cnt`=0.
- **STOP:**
  - On a tick with `stop_cnt` < STOP_BITS-1: increment `stop_cnt`, keep `txd`=1.
  - On the tick ending the last stop bit:
    - If `fifo_count`≠0, pop, drive `txd`=0 and go to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- **Bit duration:** each bit holds `txd` for exactly one tick interval.
- **`busy`:** equals (state≠IDLE) | (`fifo_count`≠0).
- **Reset (async, any time including mid-frame):**
  - The frame is aborted and the FIFO is emptied.
  - `txd`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, state IDLE.
  - Pointers, `bit_idx` and `stop_cnt` are cleared.
  - Resets mid-frame leave no partial-frame residue.

## Timing
- **`txd`:** registered. It changes on the first `clk` edge where `baud_tick`=1 is sampled, so it is visible one cycle after the strobe is asserted.
- **`tx_ready`:** combinational from `fifo_count` only, with no dependence on `tx_valid`. `tx_ready` and `fifo_count` update on the edge after a push.
- **Same-cycle push into an empty FIFO:** the byte is not visible to the FSM until the next edge. A tick in that same cycle does not start a frame.
- **Push-to-start-bit latency:** between 1 cycle and one full tick period plus 1 cycle when IDLE.
- **Frame length:** 1 + DATA_BITS + (PARITY≠0) + STOP_BITS tick intervals.
- **`baud_tick` held high:** one bit is sent per cycle, so a single pulse is needed per interval. The block needs no knowledge of the tick period.

## Test plan
- **8N1 single byte:** bench ticks every 10 cycles; push 0x55.
  - Expect `txd` = 0,1,0,1,0,1,0,1,0,1, each held 10 cycles.
  - Then `txd`=1, and `busy` falls on the edge that ends the stop bit.
- **Back-to-back:** push 0xA3 then 0x3C before the first tick.
  - Expect 20 contiguous bit periods with no idle between the frames.
  - LSB-first patterns: 1,1,0,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- **FIFO full:** FIFO_DEPTH=4, no ticks, push 5 bytes.
  - `tx_ready` drops after the 4th push and `fifo_count`=4; the 5th byte is not accepted.
  - After one tick: `fifo_count`=3, `tx_ready`=1.
- **Parity:** send 0x07.
  - PARITY=1: parity bit 1. PARITY=2: parity bit 0.
  - Frame length is 11 ticks with STOP_BITS=1.
- **Two stop bits:** STOP_BITS=2, send 0x00.
  - `txd` low for 9 intervals, then high for exactly 2 intervals before the next queued frame's start bit.
- **Reset mid-frame:** pulse `rst` during data bit 3 of 0x0F.
  - `txd`=1 immediately (async), `fifo_count`=0, `busy`=0.
  - The next pushed byte sends a clean full frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: small FIFO feeding a baud-tick-paced frame serializer.
// Frame is start, DATA_BITS LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          baud_tick,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AddrW = $clog2(FIFO_DEPTH);
   localparam int IdxW  = $clog2(DATA_BITS);
   localparam logic [IdxW-1:0]  LastBit = IdxW'(DATA_BITS - 1);
   localparam logic [AddrW:0]   FullCnt = (AddrW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

   state_e                 state_q, state_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic                   txd_q, txd_d;
   logic                   parity_q, parity_d;

   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [AddrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AddrW:0]         count_q;
   logic                   push, pop, fifo_nonempty;
   logic [DATA_BITS-1:0]   head;
   logic                   head_parity;

   assign tx_ready      = (count_q != FullCnt);
   assign push          = tx_valid & tx_ready;
   assign fifo_nonempty = (count_q != '0);
   assign head          = mem_q[rd_ptr_q];
   assign head_parity   = (^head) ^ (PARITY == 2);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b1;
         parity_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         txd_q      <= txd_d;
         parity_q   <= parity_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      txd_d      = txd_q;
      parity_d   = parity_q;
      pop        = 1'b0;
      if (baud_tick) begin
         case (state_q)
            StIdle: begin
               if (fifo_nonempty) begin
                  pop      = 1'b1;
                  shift_d  = head;
                  parity_d = head_parity;
                  txd_d    = 1'b0;
                  state_d  = StStart;
               end
            end
            StStart: begin
               txd_d     = shift_q[0];
               bit_idx_d = '0;
               state_d   = StData;
            end
            StData: begin
               if (bit_idx_q != LastBit) begin
                  shift_d   = shift_q >> 1;
                  txd_d     = shift_q[1];
                  bit_idx_d = bit_idx_q + 1'b1;
               end else if (PARITY != 0) begin
                  txd_d   = parity_q;
                  state_d = StPar;
               end else begin
                  txd_d      = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = StStop;
               end
            end
            StPar: begin
               txd_d      = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = StStop;
            end
            StStop: begin
               if ((STOP_BITS == 2) && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else if (fifo_nonempty) begin
                  // Next byte already queued: start bit follows with no idle gap.
                  pop      = 1'b1;
                  shift_d  = head;
                  parity_d = head_parity;
                  txd_d    = 1'b0;
                  state_d  = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign txd        = txd_q;
   assign busy       = (state_q != StIdle) | fifo_nonempty;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8N2, 8E1, 8O1) checked against an
// expected-bitstream model built from frame rules; random byte bursts included.
module tb_uart_tx;

   localparam int NDUT = 4;
   localparam int TICK = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_tick = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid   [NDUT];
   logic       tx_ready   [NDUT];
   logic       txd        [NDUT];
   logic       busy       [NDUT];
   logic [2:0] fifo_count [NDUT];

   logic tick_en = 1'b0;
   logic force_tick = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      uart_tx #(
         .DATA_BITS (8),
         .FIFO_DEPTH(4),
         .PARITY    (g >= 2 ? g - 1 : 0),
         .STOP_BITS (g == 1 ? 2 : 1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .baud_tick (baud_tick),
         .tx_data   (tx_data),
         .tx_valid  (tx_valid[g]),
         .tx_ready  (tx_ready[g]),
         .txd       (txd[g]),
         .busy      (busy[g]),
         .fifo_count(fifo_count[g])
      );
   end

   // Tick strobe changes just after posedge so it is stable at the sampling edge.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #2;
         baud_tick = force_tick || (tick_en && ph == 0);
         ph = (ph == TICK - 1) ? 0 : ph + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int par_of(int k);
      return (k >= 2) ? k - 1 : 0;
   endfunction

   function automatic int stop_of(int k);
      return (k == 1) ? 2 : 1;
   endfunction

   function automatic void add_frame(int k, logic [7:0] b);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      if (par_of(k) == 1) exp_q.push_back(($countones(b) % 2) == 1);
      if (par_of(k) == 2) exp_q.push_back(($countones(b) % 2) == 0);
      for (int i = 0; i < stop_of(k); i++) exp_q.push_back(1'b1);
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_byte(int k, logic [7:0] b);
      int w;
      w = 0;
      tx_data = b;
      tx_valid[k] = 1'b1;
      while (tx_ready[k] !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) check("push_timeout", 0, 1);
      @(negedge clk);
      tx_valid[k] = 1'b0;
   endtask

   // Each expected bit must hold for exactly one tick period, frames contiguous.
   task automatic expect_stream(int k, string tag);
      int w;
      w = 0;
      while (txd[k] !== 1'b0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (w >= 400) begin
         check({tag, " start_timeout"}, 1, 0);
         exp_q.delete();
         return;
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         bit b;
         int bad;
         b = exp_q.pop_front();
         bad = 0;
         for (int s = 0; s < TICK; s++) begin
            if (i > 0 || s > 0) @(negedge clk);
            if (txd[k] !== b) bad++;
         end
         check($sformatf("%s d%0d bit%0d mismatched_samples", tag, k, i), bad, 0);
      end
   endtask

   task automatic end_check(int k, string tag);
      check($sformatf("%s d%0d busy_in_stop", tag, k), busy[k], 1);
      @(negedge clk);
      check($sformatf("%s d%0d busy_after", tag, k), busy[k], 0);
      check($sformatf("%s d%0d txd_idle", tag, k), txd[k], 1);
   endtask

   task automatic send_bytes(int k, string tag, logic [7:0] bytes[$]);
      foreach (bytes[i]) add_frame(k, bytes[i]);
      fork
         begin
            foreach (bytes[i]) push_byte(k, bytes[i]);
         end
         expect_stream(k, tag);
      join
      end_check(k, tag);
   endtask

   initial begin
      logic [7:0] bq[$];
      int bad;
      for (int k = 0; k < NDUT; k++) tx_valid[k] = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("reset d%0d txd", k), txd[k], 1);
         check($sformatf("reset d%0d tx_ready", k), tx_ready[k], 1);
         check($sformatf("reset d%0d busy", k), busy[k], 0);
         check($sformatf("reset d%0d fifo_count", k), fifo_count[k], 0);
      end

      tick_en = 1'b1;
      send_bytes(0, "8n1_55", '{8'h55});
      send_bytes(0, "b2b", '{8'hA3, 8'h3C});
      send_bytes(2, "even_07", '{8'h07});
      send_bytes(3, "odd_07", '{8'h07});
      send_bytes(1, "stop2_00", '{8'h00, 8'h00});

      for (int k = 0; k < NDUT; k++) begin
         for (int r = 0; r < 2; r++) begin
            bq.delete();
            repeat ($urandom_range(1, 4)) bq.push_back(8'($urandom));
            send_bytes(k, $sformatf("rand_r%0d", r), bq);
         end
      end

      // FIFO full with ticks stopped.
      tick_en = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         push_byte(0, 8'($urandom));
         check($sformatf("full count_after_push%0d", i), fifo_count[0], i + 1);
      end
      check("full tx_ready", tx_ready[0], 0);
      tx_data = 8'hEE;
      tx_valid[0] = 1'b1;
      @(negedge clk);
      tx_valid[0] = 1'b0;
      check("full fifth_ignored_count", fifo_count[0], 4);
      force_tick = 1'b1;
      @(negedge clk);
      force_tick = 1'b0;
      @(negedge clk);
      check("full count_after_tick", fifo_count[0], 3);
      check("full ready_after_tick", tx_ready[0], 1);
      check("full start_bit", txd[0], 0);
      rst = 1'b1;
      #1;
      check("async_rst txd", txd[0], 1);
      check("async_rst count", fifo_count[0], 0);
      check("async_rst busy", busy[0], 0);
      check("async_rst ready", tx_ready[0], 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset during data bit 3 of 0x0F.
      tick_en = 1'b1;
      push_byte(0, 8'h0F);
      bad = 0;
      while (txd[0] !== 1'b0 && bad < 400) begin
         @(negedge clk);
         bad++;
      end
      check("midrst start_seen", (bad < 400), 1);
      repeat (4 * TICK + 3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst txd", txd[0], 1);
      check("midrst fifo_count", fifo_count[0], 0);
      check("midrst busy", busy[0], 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 3 * TICK; c++) begin
         @(negedge clk);
         if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      end
      check("midrst no_residue", bad, 0);
      send_bytes(0, "after_rst", '{8'h0F});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
